// File: rtl/fnn_pkg.sv
// Shared definitions for the neuron datapath: sequencer state encoding and pair-bus helpers.
// No logic; compile before any module that imports it.
// Widths are derived from the per-instance data_width parameter.
package fnn_pkg;

   // Sequencer states: IDLE waits for start, RUN accepts activations and issues reads,
   // DRAIN waits for the last pair to leave, DONE pulses done for one cycle.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef logic [1:0] seq_state_t;

   // Width of a {weight, activation} pair travelling to the MAC.
   function automatic int pair_bus_width(input int data_width);
      return 2 * data_width;
   endfunction

   // Width of the weight half of a pair bus.
   function automatic int pair_weight_width(input int data_width);
      return data_width;
   endfunction

endpackage

// File: rtl/weight_fetch_sequencer.sv
// Sequences one pass over weight_mem, pairing each accepted activation with its weight.
// Latency: activation accepted at cycle N -> pair valid at N+1; one pair per cycle sustained.
// Backpressure: pair_ready=0 holds the pair and drops x_ready/r_en so weight_mem holds w_out.
module weight_fetch_sequencer
   import fnn_pkg::*;
#(
   parameter int num_weight    = 3,
   parameter int address_width = 2,
   parameter int data_width    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic [data_width-1:0]    x_in,
   input  logic                     x_valid,
   output logic                     x_ready,
   output logic                     r_en,
   output logic [address_width-1:0] r_add,
   input  logic [data_width-1:0]    w_out,
   output logic [data_width-1:0]    pair_w,
   output logic [data_width-1:0]    pair_x,
   output logic                     pair_valid,
   output logic                     pair_last,
   input  logic                     pair_ready
);

   // Address of the final weight in a pass.
   localparam logic [address_width-1:0] LAST_IDX = address_width'(num_weight - 1);

   seq_state_t                 state_q, state_d;
   logic [address_width-1:0]   cnt_q, cnt_d;
   logic [data_width-1:0]      pair_x_q, pair_x_d;
   logic                       pair_valid_q, pair_valid_d;
   logic                       pair_last_q, pair_last_d;

   logic                       accept;
   logic                       pair_hs;
   logic                       cnt_is_last;

   assign pair_hs     = pair_valid_q & pair_ready;
   assign cnt_is_last = (cnt_q == LAST_IDX);
   assign accept      = x_valid & x_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the last read moves RUN to DRAIN, the last pair handshake moves DRAIN to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)                         state_d = ST_RUN;
         ST_RUN:   if (accept && cnt_is_last)         state_d = ST_DRAIN;
         ST_DRAIN: if (pair_hs && pair_last_q)        state_d = ST_DONE;
         ST_DONE:                                     state_d = ST_IDLE;
         default:                                     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: activations are only taken in RUN when the pair slot is free or draining.
   always_comb begin
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_DONE);
      x_ready = (state_q == ST_RUN) && (!pair_valid_q || pair_ready);
      r_en    = 1'b0;
      r_en    = x_valid && x_ready;
   end

   // Datapath registers: counter and the pair register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         pair_x_q     <= '0;
         pair_valid_q <= 1'b0;
         pair_last_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         pair_x_q     <= pair_x_d;
         pair_valid_q <= pair_valid_d;
         pair_last_q  <= pair_last_d;
      end
   end

   // Datapath next values: load on accept, retire on a handshake with nothing new behind it.
   always_comb begin
      cnt_d        = cnt_q;
      pair_x_d     = pair_x_q;
      pair_valid_d = pair_valid_q;
      pair_last_d  = pair_last_q;
      if (accept) begin
         pair_x_d     = x_in;
         pair_valid_d = 1'b1;
         pair_last_d  = cnt_is_last;
         cnt_d        = cnt_is_last ? '0 : cnt_q + 1'b1;
      end else if (pair_hs) begin
         pair_valid_d = 1'b0;
         pair_last_d  = 1'b0;
      end
   end

   // weight_mem returns data one cycle after r_en and holds it otherwise, so it lines up with pair_x.
   assign r_add      = cnt_q;
   assign pair_w     = w_out;
   assign pair_x     = pair_x_q;
   assign pair_valid = pair_valid_q;
   assign pair_last  = pair_last_q;

endmodule
